// File: rtl/hash_msg_feeder.sv
// hash_msg_feeder: buffers one byte-stream message, then replays it to the
// hash core one M_valid pulse per byte and captures the resulting digest.
// Optional build macro FEEDER_TIMEOUT_EN adds a WAIT_HI watchdog (TIMEOUT
// parameter) that aborts the message and pulses err_timeout.
//
// state   | meaning
// --------+-------------------------------------------------------------
// COLLECT | accept beats into the buffer, count length
// DROP    | discard the rest of an overlong message
// ISSUE   | wait for hash_ready, then pulse M_valid with the next byte
// WAIT_LO | one cycle ignoring hash_ready while the core drops it
// WAIT_HI | wait for the core to become ready again
// DONE    | capture digest, pulse digest_valid, return to COLLECT
module hash_msg_feeder #(
    parameter int DEPTH = 64
`ifdef FEEDER_TIMEOUT_EN
    , parameter int TIMEOUT = 1024
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    input  logic        in_empty,
    output logic        M_valid,
    output logic [7:0]  message,
    output logic [63:0] counter,
    input  logic        hash_ready,
    input  logic [31:0] digest_in,
    output logic [31:0] digest_out,
    output logic        digest_valid,
    output logic        busy,
    output logic        err_overflow
`ifdef FEEDER_TIMEOUT_EN
    , output logic      err_timeout
`endif
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [2:0] {COLLECT, DROP, ISSUE, WAIT_LO, WAIT_HI, DONE} state_t;

    state_t        state, state_nxt;
    logic [7:0]    msg_buf [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] len, sent;
    logic          drop_done;
    logic          beat, full, has_byte, store, overflow_beat, remaining;
    logic          timeout_hit;

    assign beat          = in_valid & in_ready;
    assign full          = (len == LW'(DEPTH));
    assign has_byte      = ~(in_last & in_empty);
    assign store         = beat && (state == COLLECT) && !full && has_byte;
    assign overflow_beat = beat && (state == COLLECT) && full && has_byte;
    assign remaining     = (sent < len);

`ifdef FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmr;
    assign timeout_hit = (state == WAIT_HI) && !hash_ready && (tmr == '0);
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (beat) begin
                if (overflow_beat) state_nxt = DROP;
                else if (in_last)  state_nxt = ISSUE;
            end
            DROP:    if (drop_done || (beat && in_last)) state_nxt = COLLECT;
            ISSUE:   if (hash_ready) state_nxt = WAIT_LO;
            WAIT_LO: state_nxt = WAIT_HI;
            WAIT_HI: begin
                if (hash_ready)       state_nxt = remaining ? ISSUE : DONE;
                else if (timeout_hit) state_nxt = COLLECT;
            end
            DONE:    state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    // Output decode; the single DROP cycle after an overflowing last beat
    // refuses input so the next message's first beat is not swallowed
    always_comb begin
        busy     = (state != COLLECT);
        in_ready = (state == COLLECT) || ((state == DROP) && !drop_done);
    end

    // Message buffer write (contents need no reset)
    always_ff @(posedge clk) begin
        if (store) msg_buf[wr_ptr] <= in_data;
    end

    // Pointers, length, registered outputs and error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            len          <= '0;
            sent         <= '0;
            drop_done    <= 1'b0;
            M_valid      <= 1'b0;
            message      <= 8'h00;
            counter      <= 64'd0;
            digest_out   <= 32'd0;
            digest_valid <= 1'b0;
            err_overflow <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
            err_timeout  <= 1'b0;
            tmr          <= '0;
`endif
        end else begin
            M_valid      <= 1'b0;
            digest_valid <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
            err_timeout  <= 1'b0;
`endif
            case (state)
                COLLECT: begin
                    if (store) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        len    <= len + 1'b1;
                    end
                    if (overflow_beat) begin
                        err_overflow <= 1'b1;
                        drop_done    <= in_last;
                    end else if (beat) begin
                        err_overflow <= 1'b0;
                    end
                end
                DROP: if (drop_done || (beat && in_last)) begin
                    wr_ptr    <= '0;
                    rd_ptr    <= '0;
                    len       <= '0;
                    sent      <= '0;
                    drop_done <= 1'b0;
                end
                ISSUE: if (hash_ready) begin
                    M_valid <= 1'b1;
                    message <= (len == '0) ? 8'h00 : msg_buf[rd_ptr];
                    counter <= {{(64-LW){1'b0}}, len};
                    rd_ptr  <= rd_ptr + 1'b1;
                    sent    <= sent + 1'b1;
                end
`ifdef FEEDER_TIMEOUT_EN
                WAIT_LO: tmr <= TW'(TIMEOUT - 1);
`endif
                WAIT_HI: begin
`ifdef FEEDER_TIMEOUT_EN
                    if (tmr != '0) tmr <= tmr - 1'b1;
                    if (timeout_hit) err_timeout <= 1'b1;
`endif
                    if (timeout_hit) begin
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                        len    <= '0;
                        sent   <= '0;
                    end
                end
                DONE: begin
                    digest_out   <= digest_in;
                    digest_valid <= 1'b1;
                    wr_ptr       <= '0;
                    rd_ptr       <= '0;
                    len          <= '0;
                    sent         <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hash_msg_feeder.sv
// Bench for hash_msg_feeder (DEPTH=4). A small core model answers M_valid
// pulses, drops hash_ready for a few cycles and hands back a token digest
// chosen per message; a scoreboard holds expected pulses and digests.
module tb_hash_msg_feeder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_last = 1'b0, in_empty = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, M_valid, digest_valid, busy, err_overflow;
    logic [7:0]  message;
    logic [63:0] counter;
    logic [31:0] digest_out;
    logic [31:0] digest_in = 32'h0;
    logic        hash_ready;
    logic        core_rdy = 1'b1, hr_force = 1'b0;

    assign hash_ready = core_rdy & ~hr_force;

    hash_msg_feeder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_empty(in_empty),
        .M_valid(M_valid), .message(message), .counter(counter),
        .hash_ready(hash_ready), .digest_in(digest_in),
        .digest_out(digest_out), .digest_valid(digest_valid),
        .busy(busy), .err_overflow(err_overflow)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [7:0]  msg;
        logic [63:0] cnt;
        bit          last;
        bit          first;
        logic [31:0] dig;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] dig_q[$];
    logic [7:0]  msg_q[$];

    int n_vec = 0, n_err = 0, n_pulse = 0, n_dig = 0;
    int cyc = 0, last_pulse = -100, core_cnt = 0;
    bit pend_last = 1'b0;
    logic [31:0] pend_dig = 32'h0;

    always @(posedge clk) cyc++;

    // Core model and scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            core_rdy  = 1'b1;
            core_cnt  = 0;
            pend_last = 1'b0;
        end else begin
            if (M_valid) begin
                n_pulse++;
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_pulse: message=%h counter=%0d, no pulse expected", message, counter);
                end else begin
                    e = sb_q.pop_front();
                    if (message !== e.msg || counter !== e.cnt) begin
                        n_err++;
                        $display("FAIL pulse_data: got message=%h counter=%0d, expected message=%h counter=%0d",
                                 message, counter, e.msg, e.cnt);
                    end
                    if (!e.first) begin
                        n_vec++;
                        if (cyc - last_pulse < 3) begin
                            n_err++;
                            $display("FAIL pulse_spacing: got %0d cycles, expected >= 3", cyc - last_pulse);
                        end
                    end
                    pend_last = e.last;
                    pend_dig  = e.dig;
                    if (e.last) digest_in = ~e.dig;
                end
                last_pulse = cyc;
                core_rdy   = 1'b0;
                core_cnt   = 3;
            end else if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    if (pend_last) digest_in = pend_dig;
                    pend_last = 1'b0;
                    core_rdy  = 1'b1;
                end
            end
            if (digest_valid) begin
                n_dig++;
                n_vec++;
                if (dig_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_digest: digest_out=%h, no digest expected", digest_out);
                end else begin
                    pend_dig = dig_q.pop_front();
                    if (digest_out !== pend_dig) begin
                        n_err++;
                        $display("FAIL digest: got %h expected %h", digest_out, pend_dig);
                    end
                end
            end
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic last, input logic empty);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = last; in_empty = empty;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_vec++; n_err++;
            $display("FAIL beat_accept: in_ready stayed %b for %0d cycles, expected 1", in_ready, t);
        end
        @(posedge clk);
        #1 in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
    endtask

    task automatic send_msg(input logic [31:0] dig);
        int n = msg_q.size();
        dig_q.push_back(dig);
        if (n == 0) begin
            sb_q.push_back('{msg: 8'h00, cnt: 64'd0, last: 1'b1, first: 1'b1, dig: dig});
            send_beat(8'h00, 1'b1, 1'b1);
        end else begin
            for (int i = 0; i < n; i++)
                sb_q.push_back('{msg: msg_q[i], cnt: 64'(n), last: (i == n - 1), first: (i == 0), dig: dig});
            for (int i = 0; i < n; i++)
                send_beat(msg_q[i], (i == n - 1), 1'b0);
        end
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        @(negedge clk);
        while ((sb_q.size() != 0 || dig_q.size() != 0 || busy !== 1'b0) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (t >= 1000) begin
            n_err++;
            $display("FAIL %s_idle: pending pulses=%0d digests=%0d busy=%b, expected 0/0/0",
                     name, sb_q.size(), dig_q.size(), busy);
        end
    endtask

    task automatic check_pulses(input string name, input int exp_p, input int exp_d);
        n_vec++;
        if (n_pulse !== exp_p || n_dig !== exp_d) begin
            n_err++;
            $display("FAIL %s_count: got pulses=%0d digests=%0d, expected pulses=%0d digests=%0d",
                     name, n_pulse, n_dig, exp_p, exp_d);
        end
    endtask

    task automatic check_reset_vals(input string name);
        n_vec++;
        if ({M_valid, digest_valid, busy, err_overflow, in_ready} !== 5'b00001 ||
            message !== 8'h00 || counter !== 64'd0 || digest_out !== 32'd0) begin
            n_err++;
            $display("FAIL %s: got mv=%b dv=%b busy=%b ovf=%b rdy=%b msg=%h cnt=%0d dig=%h, expected 0 0 0 0 1 00 0 0",
                     name, M_valid, digest_valid, busy, err_overflow, in_ready, message, counter, digest_out);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset_state");
        rst_n = 1'b1;
    endtask

    task automatic test_empty();
        n_pulse = 0; n_dig = 0;
        msg_q = {};
        send_msg(32'h956F7883);
        wait_idle("empty");
        check_pulses("empty", 1, 1);
    endtask

    task automatic test_single();
        n_pulse = 0; n_dig = 0;
        msg_q = {8'h41};
        send_msg(32'h2dd99066);
        wait_idle("single");
        check_pulses("single", 1, 1);
        n_vec++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single_busy: got busy=%b in_ready=%b, expected 0 1", busy, in_ready);
        end
    endtask

    task automatic test_abc();
        n_pulse = 0; n_dig = 0;
        msg_q = {8'h41, 8'h42, 8'h43};
        send_msg(32'hA1B2C3D4);
        wait_idle("abc");
        check_pulses("abc", 3, 1);
    endtask

    task automatic test_full_depth();
        n_pulse = 0; n_dig = 0;
        msg_q = {8'h10, 8'h20, 8'h30, 8'h40};
        send_msg(32'h0BAD_F00D);
        wait_idle("full_depth");
        check_pulses("full_depth", 4, 1);
        n_vec++;
        if (err_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL full_depth_ovf: got %b expected 0", err_overflow);
        end
    endtask

    task automatic test_stall();
        bit bad = 1'b0;
        n_pulse = 0; n_dig = 0;
        hr_force = 1'b1;
        msg_q = {8'h5A};
        send_msg(32'h5A5A_0001);
        repeat (10) begin
            @(negedge clk);
            if (M_valid !== 1'b0 || in_ready !== 1'b0) bad = 1'b1;
        end
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL stall_hold: got a pulse or in_ready=1 during stall, expected neither");
        end
        hr_force = 1'b0;
        @(negedge clk);
        n_vec++;
        if (M_valid !== 1'b1) begin
            n_err++;
            $display("FAIL stall_release: got M_valid=%b one edge after hash_ready rose, expected 1", M_valid);
        end
        wait_idle("stall");
        check_pulses("stall", 1, 1);
    endtask

    task automatic test_overflow();
        bit bad = 1'b0;
        n_pulse = 0; n_dig = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (in_ready !== 1'b1) bad = 1'b1;
            send_beat(8'(8'h61 + i), (i == 5), 1'b0);
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if (bad || err_overflow !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL overflow_flag: got ready_drop=%b ovf=%b busy=%b, expected 0 1 0", bad, err_overflow, busy);
        end
        check_pulses("overflow", 0, 0);
        msg_q = {8'h51};
        send_msg(32'h5151_5151);
        n_vec++;
        if (err_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL overflow_clear: got %b expected 0", err_overflow);
        end
        wait_idle("overflow_next");
        check_pulses("overflow_next", 1, 1);
    endtask

    task automatic test_overflow_last();
        n_pulse = 0; n_dig = 0;
        for (int i = 0; i < 5; i++) send_beat(8'(8'h71 + i), (i == 4), 1'b0);
        repeat (3) @(negedge clk);
        n_vec++;
        if (err_overflow !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL overflow_last_flag: got ovf=%b busy=%b, expected 1 0", err_overflow, busy);
        end
        msg_q = {8'h01, 8'h02};
        send_msg(32'hCAFE_0102);
        wait_idle("overflow_last_next");
        check_pulses("overflow_last_next", 2, 1);
    endtask

    task automatic test_back_to_back();
        n_pulse = 0; n_dig = 0;
        msg_q = {8'h41, 8'h42};
        send_msg(32'h1111_2222);
        msg_q = {8'h43};
        send_msg(32'h3333_4444);
        wait_idle("back_to_back");
        check_pulses("back_to_back", 3, 2);
    endtask

    task automatic test_reset_mid();
        int t = 0;
        n_pulse = 0; n_dig = 0;
        msg_q = {8'h41, 8'h42, 8'h43};
        send_msg(32'hDEAD_0003);
        while (n_pulse < 2 && t < 500) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (t >= 500) begin
            n_err++;
            $display("FAIL reset_mid_wait: got %0d pulses, expected 2", n_pulse);
        end
        @(negedge clk);
        rst_n = 1'b0;
        sb_q.delete();
        dig_q.delete();
        #1 check_reset_vals("reset_mid_state");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n_pulse = 0; n_dig = 0;
        repeat (12) @(negedge clk);
        check_pulses("reset_mid_quiet", 0, 0);
        msg_q = {8'h41};
        send_msg(32'h2dd99066);
        wait_idle("reset_mid_next");
        check_pulses("reset_mid_next", 1, 1);
    endtask

    initial begin
        test_reset();
        test_empty();
        test_single();
        test_abc();
        test_full_depth();
        test_stall();
        test_overflow();
        test_overflow_last();
        test_back_to_back();
        test_reset_mid();
        repeat (5) @(negedge clk);
        n_vec++;
        if (sb_q.size() != 0 || dig_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover: got pulses=%0d digests=%0d outstanding, expected 0", sb_q.size(), dig_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
